// File: rtl/dac_ramp_sequencer.sv
// dac_ramp_sequencer: queues ramp setpoint commands and sequences them into the DAC ramp generator
module dac_ramp_sequencer #(
    parameter int DEPTH    = 4,
    parameter int PRESCALE = 100,
    parameter int SETTLE   = 3
) (
    input  logic                      clk,
    input  logic                      nReset,
    input  logic                      enable,
    input  logic                      abort,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [15:0]        cmd_yset,
    input  logic signed [15:0]        cmd_rate,
    input  logic signed [15:0]        cmd_accel,
    input  logic signed [15:0]        cmd_round,
    input  logic        [15:0]        cmd_dwell,
    input  logic signed [31:0]        Yis,
    input  logic signed [31:0]        Ris,
    output logic                      timepulse,
    output logic signed [15:0]        Yset,
    output logic signed [15:0]        Rset,
    output logic signed [15:0]        RIset,
    output logic signed [15:0]        ROset,
    output logic [$clog2(DEPTH):0]    fill,
    output logic                      busy,
    output logic                      seq_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(PRESCALE);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RAMP, S_SETTLE, S_DWELL} state_t;

    state_t          state, nxt;
    logic [PW-1:0]   pre_cnt;
    logic [79:0]     mem [DEPTH];
    logic [79:0]     head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [SW-1:0]   settle_cnt;
    logic [15:0]     dwell_cnt;
    logic            push, pop, arrived, sample;

    assign timepulse = enable && pre_cnt == PW'(PRESCALE - 1);
    assign cmd_ready = fill != (AW + 1)'(DEPTH) && !abort;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state == S_LOAD && !abort;
    assign head      = mem[rd_ptr];
    assign arrived   = Yis == {{16{Yset[15]}}, Yset} && Ris == '0;
    assign sample    = timepulse && arrived;
    assign busy      = state != S_IDLE;

    // Prescaler: free-runs while enabled, held at zero otherwise
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) pre_cnt <= '0;
        else pre_cnt <= (!enable || timepulse) ? '0 : pre_cnt + 1'b1;
    end

    // Command storage; no reset needed since occupancy is tracked by fill
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_yset, cmd_rate, cmd_accel, cmd_round, cmd_dwell};
    end

    // FIFO pointers and occupancy; abort flushes the queue
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            fill   <= fill + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // State register
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= S_IDLE;
        else state <= nxt;
    end

    // Next-state: arrival only matters on timepulse cycles, abort overrides everything
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (enable && fill != '0) nxt = S_LOAD;
            S_LOAD:   nxt = S_RAMP;
            S_RAMP:   if (sample) nxt = (SETTLE == 1) ? S_DWELL : S_SETTLE;
            S_SETTLE: if (timepulse) nxt = !arrived ? S_RAMP : (settle_cnt == SW'(SETTLE - 1)) ? S_DWELL : S_SETTLE;
            S_DWELL:  if (dwell_cnt == '0) nxt = (fill != '0) ? S_LOAD : S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        if (abort) nxt = S_IDLE;
    end

    // Generator setpoints, settle/dwell counters and completion pulse
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            Yset       <= '0;
            Rset       <= '0;
            RIset      <= '0;
            ROset      <= 16'sd1;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
            seq_done   <= 1'b0;
        end else begin
            seq_done <= !abort && state == S_DWELL && dwell_cnt == '0 && fill == '0;
            if (abort) begin
                Yset <= Yis[15:0];
            end else if (state == S_LOAD) begin
                Yset       <= head[79:64];
                Rset       <= head[63:48];
                RIset      <= head[47:32];
                ROset      <= (head[31:16] == '0) ? 16'sd1 : head[31:16];
                dwell_cnt  <= head[15:0];
                settle_cnt <= '0;
            end else if (state == S_RAMP && sample) begin
                settle_cnt <= SW'(1);
            end else if (state == S_SETTLE && timepulse) begin
                settle_cnt <= arrived ? settle_cnt + 1'b1 : '0;
            end else if (state == S_DWELL && timepulse && dwell_cnt != '0) begin
                dwell_cnt <= dwell_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// tb_dac_ramp_sequencer: directed self-checking bench for dac_ramp_sequencer
module tb_dac_ramp_sequencer;
    logic               clk = 0, nReset = 1, enable = 0, abort = 0, cmd_valid = 0;
    logic signed [15:0] cmd_yset = 0, cmd_rate = 0, cmd_accel = 0, cmd_round = 0;
    logic        [15:0] cmd_dwell = 0;
    logic signed [31:0] Yis = 0, Ris = 0;
    logic               cmd_ready, timepulse, busy, seq_done;
    logic signed [15:0] Yset, Rset, RIset, ROset;
    logic [2:0]         fill;
    int                 checks = 0, errs = 0;
    logic signed [15:0] ys [5];
    logic [15:0]        dw [5];
    int                 n;

    always #5 clk = ~clk;

    dac_ramp_sequencer #(.DEPTH(4), .PRESCALE(4), .SETTLE(3)) dut (
        .clk(clk), .nReset(nReset), .enable(enable), .abort(abort),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_yset(cmd_yset), .cmd_rate(cmd_rate), .cmd_accel(cmd_accel),
        .cmd_round(cmd_round), .cmd_dwell(cmd_dwell),
        .Yis(Yis), .Ris(Ris), .timepulse(timepulse),
        .Yset(Yset), .Rset(Rset), .RIset(RIset), .ROset(ROset),
        .fill(fill), .busy(busy), .seq_done(seq_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tp_step();
        int k = 0;
        while (!timepulse && k < 20) begin
            tick();
            k++;
        end
        chk("tp_wait", {31'd0, timepulse}, 32'd1);
        tick();
    endtask

    task automatic wait_yset(input logic signed [15:0] v);
        int k = 0;
        while (Yset !== v && k < 300) begin
            tick();
            k++;
        end
        chk("yset_order", {16'd0, Yset}, {16'd0, v});
    endtask

    task automatic push(input logic signed [15:0] y, input logic signed [15:0] r, input logic signed [15:0] a,
                        input logic signed [15:0] ro, input logic [15:0] d);
        cmd_yset = y; cmd_rate = r; cmd_accel = a; cmd_round = ro; cmd_dwell = d;
        cmd_valid = 1;
        tick();
        cmd_valid = 0;
    endtask

    function automatic logic signed [31:0] sx(input logic signed [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    initial begin
        ys = '{16'sd1000, 16'sd2000, -16'sd3000, 16'sd4000, 16'sd5000};
        dw = '{16'd0, 16'd1, 16'd0, 16'd0, 16'd0};
        // reset values
        #2 nReset = 0;
        #1;
        chk("rst_fill", {29'd0, fill}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tp", {31'd0, timepulse}, 0);
        chk("rst_yset", {16'd0, Yset}, 0);
        chk("rst_roset", {16'd0, ROset}, 1);
        chk("rst_done", {31'd0, seq_done}, 0);
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        tick();
        tick();
        nReset = 1;
        // prescaler cadence, then disable mid-count and restart from zero
        enable = 1;
        for (int i = 0; i < 6; i++) begin
            chk("tp_cadence", {31'd0, timepulse}, {31'd0, i % 4 == 3});
            tick();
        end
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            chk("tp_disabled", {31'd0, timepulse}, 0);
            tick();
        end
        enable = 1;
        for (int i = 0; i < 8; i++) begin
            chk("tp_restart", {31'd0, timepulse}, {31'd0, i % 4 == 3});
            tick();
        end
        // single command: load, settle on 3 ticks, dwell 2 ticks, done
        Yis = 100; Ris = 0;
        push(16'sd100, 16'sd10, 16'sd2, 16'sd5, 16'd2);
        chk("c1_fill", {29'd0, fill}, 1);
        chk("c1_idle", {31'd0, busy}, 0);
        tick();
        chk("c1_load_busy", {31'd0, busy}, 1);
        chk("c1_load_hold", {16'd0, Yset}, 0);
        tick();
        chk("c1_yset", {16'd0, Yset}, 100);
        chk("c1_rset", {16'd0, Rset}, 10);
        chk("c1_riset", {16'd0, RIset}, 2);
        chk("c1_roset", {16'd0, ROset}, 5);
        chk("c1_fill0", {29'd0, fill}, 0);
        for (int i = 0; i < 5; i++) tp_step();
        chk("c1_dwell_busy", {31'd0, busy}, 1);
        chk("c1_dwell_nodone", {31'd0, seq_done}, 0);
        tick();
        chk("c1_end_busy", {31'd0, busy}, 0);
        chk("c1_done", {31'd0, seq_done}, 1);
        tick();
        chk("c1_done_pulse", {31'd0, seq_done}, 0);
        // settle interrupted once, round=0 loads ROset=1, dwell=0
        Yis = sx(-16'sd200); Ris = 0;
        push(-16'sd200, 16'sd7, 16'sd1, 16'sd0, 16'd0);
        wait_yset(-16'sd200);
        chk("c2_roset1", {16'd0, ROset}, 1);
        for (int i = 0; i < 5; i++) begin
            Ris = (i == 2) ? 32'sd5 : 32'sd0;
            tp_step();
            Ris = 0;
        end
        chk("c2_not_early", {31'd0, busy}, 1);
        tp_step();
        chk("c2_dwell", {31'd0, busy}, 1);
        chk("c2_nodone", {31'd0, seq_done}, 0);
        tick();
        chk("c2_done", {31'd0, seq_done}, 1);
        chk("c2_idle", {31'd0, busy}, 0);
        // full FIFO while ramping, in-order execution
        push(ys[0], 16'sd1, 16'sd1, 16'sd3, dw[0]);
        wait_yset(ys[0]);
        for (int i = 1; i <= 5; i++) begin
            cmd_yset = (i < 5) ? ys[i] : 16'sd6000;
            cmd_rate = 16'sd2; cmd_accel = 16'sd1; cmd_round = 16'sd4;
            cmd_dwell = (i < 5) ? dw[i] : 16'd0;
            cmd_valid = 1;
            chk("c3_ready", {31'd0, cmd_ready}, {31'd0, i < 5});
            tick();
        end
        cmd_valid = 0;
        chk("c3_full", {29'd0, fill}, 4);
        chk("c3_full_ready", {31'd0, cmd_ready}, 0);
        Yis = sx(ys[0]);
        for (int i = 0; i < 3; i++) tp_step();
        chk("c3_dwell_yset", {16'd0, Yset}, {16'd0, ys[0]});
        tick();
        chk("c3_load_yset", {16'd0, Yset}, {16'd0, ys[0]});
        tick();
        chk("c3_next_yset", {16'd0, Yset}, {16'd0, ys[1]});
        chk("c3_fill3", {29'd0, fill}, 3);
        Yis = sx(ys[1]);
        for (int k = 2; k < 5; k++) begin
            wait_yset(ys[k]);
            chk("c3_fill", {29'd0, fill}, 4 - k);
            Yis = sx(ys[k]);
        end
        n = 0;
        while (!seq_done && n < 300) begin
            tick();
            n++;
        end
        chk("c3_done", {31'd0, seq_done}, 1);
        chk("c3_final_fill", {29'd0, fill}, 0);
        chk("c3_final_yset", {16'd0, Yset}, {16'd0, ys[4]});
        // abort during SETTLE with two queued
        Yis = 0;
        push(16'sd500, 16'sd33, 16'sd4, 16'sd9, 16'd0);
        push(16'sd600, 16'sd1, 16'sd1, 16'sd1, 16'd0);
        push(16'sd700, 16'sd1, 16'sd1, 16'sd1, 16'd0);
        wait_yset(16'sd500);
        chk("c4_fill2", {29'd0, fill}, 2);
        Yis = sx(16'sd500);
        tp_step();
        Yis = 32'h00012345;
        abort = 1;
        cmd_yset = 16'sd800; cmd_valid = 1;
        #1;
        chk("c4_abort_ready", {31'd0, cmd_ready}, 0);
        tick();
        abort = 0; cmd_valid = 0;
        chk("c4_busy", {31'd0, busy}, 0);
        chk("c4_fill", {29'd0, fill}, 0);
        chk("c4_yset", {16'd0, Yset}, 32'h2345);
        chk("c4_rset", {16'd0, Rset}, 33);
        chk("c4_nodone", {31'd0, seq_done}, 0);
        tick();
        chk("c4_stay_idle", {31'd0, busy}, 0);
        chk("c4_nodone2", {31'd0, seq_done}, 0);
        // asynchronous reset while dwelling
        Yis = sx(16'sd7);
        push(16'sd7, 16'sd1, 16'sd1, 16'sd2, 16'd50);
        push(16'sd8, 16'sd1, 16'sd1, 16'sd2, 16'd0);
        wait_yset(16'sd7);
        for (int i = 0; i < 3; i++) tp_step();
        tick();
        tick();
        chk("c5_dwell_busy", {31'd0, busy}, 1);
        chk("c5_fill1", {29'd0, fill}, 1);
        nReset = 0;
        #1;
        chk("c5_rst_fill", {29'd0, fill}, 0);
        chk("c5_rst_busy", {31'd0, busy}, 0);
        chk("c5_rst_yset", {16'd0, Yset}, 0);
        chk("c5_rst_rset", {16'd0, Rset}, 0);
        chk("c5_rst_roset", {16'd0, ROset}, 1);
        tick();
        nReset = 1;
        tick();
        chk("c5_after_idle", {31'd0, busy}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule
